// File: rtl/exu_div.sv
// exu_div: iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Optional macro EXU_DIV_SPECIAL_BYPASS_EN: zero-divisor/overflow finish at accept.
module exu_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  op_sel_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        flush_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [1:0]  op;
  logic        neg_q;
  logic        neg_r;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic [31:0] result;

  logic        accept;
  logic        in_signed;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        bypass;

  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [32:0] rem_n;
  logic [31:0] quo_n;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic [31:0] fin_res;
  logic        last_iter;

  assign accept    = req_valid_i & (state == IDLE) & ~flush_i;
  assign in_signed = ~op_sel_i[0];
  assign a_neg     = in_signed & dividend_i[31];
  assign b_neg     = in_signed & divisor_i[31];
  assign a_mag     = a_neg ? (~dividend_i + 32'd1) : dividend_i;
  assign b_mag     = b_neg ? (~divisor_i + 32'd1) : divisor_i;
  assign b_zero    = (divisor_i == 32'd0);

`ifdef EXU_DIV_SPECIAL_BYPASS_EN
  logic        ovf;
  logic [31:0] spec_res;

  assign ovf = in_signed & (dividend_i == 32'h8000_0000)
             & (divisor_i == 32'hFFFF_FFFF);
  assign bypass = b_zero | ovf;

  // architected result for the special cases, decided at accept
  always_comb begin
    spec_res = 32'd0;
    if (b_zero) begin
      spec_res = op_sel_i[1] ? dividend_i : 32'hFFFF_FFFF;
    end else begin
      spec_res = op_sel_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end
`else
  assign bypass = 1'b0;
`endif

  assign last_iter = (state == CALC) && (cnt == 5'd31);

  // one restoring subtract-and-shift step on the magnitudes
  always_comb begin
    rem_sh = {rem[31:0], quo[31]};
    trial  = rem_sh - {1'b0, dvs};
    rem_n  = rem_sh;
    quo_n  = {quo[30:0], 1'b0};
    if (!trial[32]) begin
      rem_n = trial;
      quo_n = {quo[30:0], 1'b1};
    end
  end

  // sign correction and quotient/remainder select for the final step
  always_comb begin
    q_fin   = neg_q ? (~quo_n + 32'd1) : quo_n;
    r_fin   = neg_r ? (~rem_n[31:0] + 32'd1) : rem_n[31:0];
    fin_res = op[1] ? r_fin : q_fin;
  end

  // next-state decode; flush wins over everything
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            state_nxt = bypass ? DONE : CALC;
          end
        end
        CALC: begin
          if (cnt == 5'd31) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (result_ready_i) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // operand latch at accept, then one iteration per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op    <= 2'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      rem   <= 33'd0;
      quo   <= 32'd0;
      dvs   <= 32'd0;
      cnt   <= 5'd0;
    end else if (accept && !bypass) begin
      op    <= op_sel_i;
      neg_q <= (a_neg ^ b_neg) & ~b_zero;
      neg_r <= a_neg;
      rem   <= 33'd0;
      quo   <= a_mag;
      dvs   <= b_mag;
      cnt   <= 5'd0;
    end else if (state == CALC && !flush_i) begin
      rem   <= rem_n;
      quo   <= quo_n;
      cnt   <= cnt + 5'd1;
    end
  end

  // result register, written only when entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= 32'd0;
    end else if (last_iter && !flush_i) begin
      result <= fin_res;
`ifdef EXU_DIV_SPECIAL_BYPASS_EN
    end else if (accept && bypass) begin
      result <= spec_res;
`endif
    end
  end

  assign req_ready_o    = (state == IDLE);
  assign result_valid_o = (state == DONE);
  assign busy_o         = (state == CALC) || (state == DONE);
  assign result_o       = result;

endmodule

// File: tb/tb_exu_div.sv
// tb_exu_div: directed self-checking bench for exu_div.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_exu_div;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op_sel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef EXU_DIV_SPECIAL_BYPASS_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 33;
`endif

  exu_div dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .op_sel_i       (op_sel),
    .dividend_i     (dividend),
    .divisor_i      (divisor),
    .flush_i        (flush),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_o       (result),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input string tag);
    int k;
    @(negedge clk);
    op_sel    = op;
    dividend  = a;
    divisor   = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!result_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(lat));
    check(tag, result, exp);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_idle"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int pulses;
    logic [31:0] held;
    rst          = 1'b1;
    req_valid    = 1'b0;
    op_sel       = 2'd0;
    dividend     = 32'd0;
    divisor      = 32'd0;
    flush        = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", result, 32'd0);

    run_op(2'b00, 32'd100, 32'd7, 32'd14, 33, "div_100_7");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, "divu_big_2");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    run_op(2'b11, 32'd1000, 32'd7, 32'd6, 33, "remu_1000_7");
    run_op(2'b00, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, "div_z");
    run_op(2'b10, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFF6, SPEC_LAT, "rem_z");
    run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, "divu_z");
    run_op(2'b11, 32'd5, 32'd0, 32'd5, SPEC_LAT, "remu_z");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
           SPEC_LAT, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT, "rem_ovf");

    // back-pressure: hold DONE ten cycles while a new request knocks
    @(negedge clk);
    op_sel    = 2'b01;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (32) @(negedge clk);
    check("bp_valid", {31'd0, result_valid}, 32'd1);
    held      = result;
    check("bp_res", held, 32'd100);
    op_sel    = 2'b00;
    dividend  = 32'd77;
    divisor   = 32'd3;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable", result, 32'd100);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
      check("bp_valid_hold", {31'd0, result_valid}, 32'd1);
    end
    req_valid    = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("bp_idle", {31'd0, req_ready}, 32'd1);
    check("bp_busy", {31'd0, busy}, 32'd0);

    // flush at CALC iteration 15
    op_sel    = 2'b00;
    dividend  = 32'd500;
    divisor   = 32'd5;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("fl_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_ready", {31'd0, req_ready}, 32'd1);
    check("fl_busy0", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("fl_no_pulse", 32'(pulses), 32'd0);

    // flush together with a request in IDLE
    req_valid = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flreq_busy", {31'd0, busy}, 32'd0);
    check("flreq_ready", {31'd0, req_ready}, 32'd1);
    repeat (40) @(negedge clk);
    check("flreq_valid", {31'd0, result_valid}, 32'd0);

    // async reset mid-CALC, off the clock edge
    op_sel    = 2'b01;
    dividend  = 32'd999;
    divisor   = 32'd9;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("ar_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_ready", {31'd0, req_ready}, 32'd1);
    check("ar_valid", {31'd0, result_valid}, 32'd0);
    check("ar_busy0", {31'd0, busy}, 32'd0);
    check("ar_result", result, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_op(2'b01, 32'd9, 32'd3, 32'd3, 33, "divu_9_3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
